// File: rtl/carregador_instrucoes.sv
// Instruction memory with a length-prefixed, checksummed program loader.
// The core is held in reset until a loaded program verifies; then words are read combinationally.
module carregador_instrucoes #(
  parameter int          PROFUNDIDADE = 256,
  parameter logic [7:0]  INSTR_PADRAO = 8'h00
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CargaValido,
  input  logic [7:0] CargaDado,
  output logic       CargaPronto,
  input  logic [7:0] Endereco,
  output logic [7:0] InstrucaoLida,
  output logic       ResetProcessador,
  output logic       Executando,
  output logic       ErroCarga,
  output logic [2:0] estado_dbg
);

  // Handshake: a loader byte moves on a rising edge where CargaValido and
  // CargaPronto are both 1; CargaPronto depends on state only.
  typedef enum logic [2:0] {
    ESPERA_TAMANHO = 3'd0,
    CARGA          = 3'd1,
    VERIFICA       = 3'd2,
    EXECUTA        = 3'd3,
    ERRO           = 3'd4
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [8:0] cont_q, cont_d;
  logic [8:0] tam_q, tam_d;
  logic [7:0] soma_q, soma_d;
  logic       erro_q, erro_d;
  logic       escreve;
  logic       transf;
  logic [7:0] mem_q [PROFUNDIDADE];

  assign CargaPronto      = (estado_q == ESPERA_TAMANHO) || (estado_q == CARGA) ||
                            (estado_q == VERIFICA);
  assign Executando       = (estado_q == EXECUTA);
  assign ResetProcessador = !Executando;
  assign ErroCarga        = erro_q;
  assign estado_dbg       = 3'(estado_q);
  assign transf           = CargaValido && CargaPronto;

  // Only words inside the current program length are visible; stale words stay hidden.
  assign InstrucaoLida = (Executando && ({1'b0, Endereco} < tam_q)) ? mem_q[Endereco]
                                                                    : INSTR_PADRAO;

  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    tam_d    = tam_q;
    soma_d   = soma_q;
    erro_d   = erro_q;
    escreve  = 1'b0;
    case (estado_q)
      ESPERA_TAMANHO: begin
        if (transf) begin
          // A length byte of zero encodes a full 256-word program.
          tam_d    = {(CargaDado == 8'h00), CargaDado};
          cont_d   = 9'd0;
          soma_d   = 8'd0;
          estado_d = CARGA;
        end
      end
      CARGA: begin
        if (transf) begin
          escreve = 1'b1;
          soma_d  = soma_q + CargaDado;
          cont_d  = cont_q + 9'd1;
          if ((cont_q + 9'd1) == tam_q) estado_d = VERIFICA;
        end
      end
      VERIFICA: begin
        if (transf) begin
          if (CargaDado == soma_q) begin
            estado_d = EXECUTA;
          end else begin
            estado_d = ERRO;
            erro_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q <= ESPERA_TAMANHO;
      cont_q   <= 9'd0;
      tam_q    <= 9'd0;
      soma_q   <= 8'd0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      tam_q    <= tam_d;
      soma_q   <= soma_d;
      erro_q   <= erro_d;
    end
  end

  // Memory is not cleared by Reset; a byte arriving with Reset is dropped.
  always_ff @(posedge Clock) begin
    if (escreve && !Reset) mem_q[cont_q[7:0]] <= CargaDado;
  end

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Bench for carregador_instrucoes: directed loads plus random programs,
// compared every cycle against a program-queue model of the loader.
module tb_carregador_instrucoes;

  logic       Clock;
  logic       Reset;
  logic       CargaValido;
  logic [7:0] CargaDado;
  logic       CargaPronto;
  logic [7:0] Endereco;
  logic [7:0] InstrucaoLida;
  logic       ResetProcessador;
  logic       Executando;
  logic       ErroCarga;
  logic [2:0] estado_dbg;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  // Model: the program is the queue of payload bytes received so far.
  bit         m_have_len, m_run, m_err;
  int         m_len;
  logic [7:0] exp_q[$];

  carregador_instrucoes dut (
    .Clock(Clock), .Reset(Reset), .CargaValido(CargaValido), .CargaDado(CargaDado),
    .CargaPronto(CargaPronto), .Endereco(Endereco), .InstrucaoLida(InstrucaoLida),
    .ResetProcessador(ResetProcessador), .Executando(Executando),
    .ErroCarga(ErroCarga), .estado_dbg(estado_dbg)
  );

  // clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nome, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nome, act, exp);
    end
  endtask

  // model update
  always @(posedge Clock) begin
    if (Reset) begin
      m_have_len = 0; m_run = 0; m_err = 0; m_len = 0;
      exp_q.delete();
    end else if (CargaValido && !m_run && !m_err) begin
      if (!m_have_len) begin
        m_len = (CargaDado == 8'h00) ? 256 : int'(CargaDado);
        m_have_len = 1;
        exp_q.delete();
      end else if (exp_q.size() < m_len) begin
        exp_q.push_back(CargaDado);
      end else begin
        logic [7:0] soma;
        soma = 8'h00;
        foreach (exp_q[i]) soma = soma + exp_q[i];
        if (soma == CargaDado) m_run = 1;
        else m_err = 1;
      end
    end
  end

  // compare process
  always @(negedge Clock) begin
    if (started) begin
      logic [7:0] exp_instr;
      exp_instr = (m_run && int'(Endereco) < exp_q.size()) ? exp_q[Endereco] : 8'h00;
      chk("m_pronto", 9'(CargaPronto), 9'(!m_run && !m_err));
      chk("m_rst_proc", 9'(ResetProcessador), 9'(!m_run));
      chk("m_exec", 9'(Executando), 9'(m_run));
      chk("m_erro", 9'(ErroCarga), 9'(m_err));
      chk("m_instr", 9'(InstrucaoLida), 9'(exp_instr));
    end
  end

  // driver tasks
  task automatic ciclo();
    @(posedge Clock);
    #1;
  endtask

  task automatic enviar(input logic [7:0] b, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin
      CargaValido = 1'b0;
      CargaDado   = 8'($urandom);
      Endereco    = 8'($urandom);
      ciclo();
    end
    CargaValido = 1'b1;
    CargaDado   = b;
    Endereco    = 8'($urandom);
    ciclo();
    CargaValido = 1'b0;
    CargaDado   = 8'($urandom);
  endtask

  task automatic pulso_reset();
    Reset = 1'b1;
    ciclo();
    Reset = 1'b0;
  endtask

  task automatic ler(input logic [7:0] a, input logic [7:0] exp, input string nome);
    Endereco = a;
    @(negedge Clock);
    chk(nome, 9'(InstrucaoLida), 9'(exp));
    #1;
  endtask

  initial begin
    Reset = 1'b1; CargaValido = 1'b0; CargaDado = 8'h00; Endereco = 8'h00;
    ciclo();
    ciclo();
    started = 1;
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_pronto", 9'(CargaPronto), 9'h1);
    chk("rst_rst_proc", 9'(ResetProcessador), 9'h1);
    chk("rst_exec", 9'(Executando), 9'h0);
    chk("rst_erro", 9'(ErroCarga), 9'h0);
    chk("rst_instr", 9'(InstrucaoLida), 9'h0);
    #1;

    // basic load
    enviar(8'h03, 0); enviar(8'h41, 0); enviar(8'h82, 0); enviar(8'h07, 0);
    enviar(8'hCA, 0);
    @(negedge Clock);
    chk("basic_exec", 9'(Executando), 9'h1);
    chk("basic_rst_proc", 9'(ResetProcessador), 9'h0);
    #1;
    ler(8'h01, 8'h82, "basic_a1");
    ler(8'h02, 8'h07, "basic_a2");
    ler(8'h03, 8'h00, "basic_a3");
    ler(8'h00, 8'h41, "basic_a0");

    // run-state: loader bytes ignored, then Reset with valid still high
    CargaValido = 1'b1;
    repeat (4) begin CargaDado = 8'($urandom); ciclo(); end
    @(negedge Clock);
    chk("run_hold_exec", 9'(Executando), 9'h1);
    #1;
    pulso_reset();
    CargaValido = 1'b0;
    @(negedge Clock);
    chk("run_rst_rst_proc", 9'(ResetProcessador), 9'h1);
    chk("run_rst_exec", 9'(Executando), 9'h0);
    chk("run_rst_pronto", 9'(CargaPronto), 9'h1);
    #1;

    // bad checksum
    enviar(8'h02, 0); enviar(8'h10, 0); enviar(8'h20, 0); enviar(8'h31, 0);
    @(negedge Clock);
    chk("bad_erro", 9'(ErroCarga), 9'h1);
    chk("bad_pronto", 9'(CargaPronto), 9'h0);
    chk("bad_rst_proc", 9'(ResetProcessador), 9'h1);
    #1;
    enviar(8'h00, 0); enviar(8'hFF, 0);
    @(negedge Clock);
    chk("bad_sticky", 9'(ErroCarga), 9'h1);
    #1;
    pulso_reset();
    @(negedge Clock);
    chk("bad_rst_pronto", 9'(CargaPronto), 9'h1);
    chk("bad_rst_erro", 9'(ErroCarga), 9'h0);
    #1;

    // full depth
    enviar(8'h00, 0);
    for (int i = 0; i < 256; i++) enviar(8'(i), 0);
    enviar(8'h80, 0);
    @(negedge Clock);
    chk("full_exec", 9'(Executando), 9'h1);
    #1;
    ler(8'hFF, 8'hFF, "full_aff");
    ler(8'h00, 8'h00, "full_a00");
    pulso_reset();

    // backpressure and gaps
    enviar(8'h01, 3); enviar(8'h55, 3); enviar(8'h55, 3);
    ler(8'h00, 8'h55, "bp_a0");
    pulso_reset();

    // reset mid-load, with a byte offered during the Reset cycle
    enviar(8'h05, 0); enviar(8'hAA, 0); enviar(8'hBB, 0);
    Reset = 1'b1; CargaValido = 1'b1; CargaDado = 8'hEE;
    ciclo();
    Reset = 1'b0; CargaValido = 1'b0;
    enviar(8'h01, 0); enviar(8'h3C, 0); enviar(8'h3C, 0);
    ler(8'h00, 8'h3C, "mid_a0");
    ler(8'h01, 8'h00, "mid_a1");
    pulso_reset();

    // random programs, some with corrupted checksums
    for (int t = 0; t < 10; t++) begin
      int n;
      logic [7:0] soma, b;
      n = int'($urandom_range(24, 1));
      soma = 8'h00;
      enviar(8'(n), 2);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        soma = soma + b;
        enviar(b, 2);
      end
      if ($urandom_range(3, 0) == 0) soma = soma + 8'h01;
      enviar(soma, 2);
      repeat (12) begin
        Endereco    = 8'($urandom_range(31, 0));
        CargaValido = 1'($urandom);
        CargaDado   = 8'($urandom);
        ciclo();
      end
      CargaValido = 1'b0;
      pulso_reset();
    end

    ciclo();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/carregador_instrucoes.md
Name: carregador_instrucoes

Overview:
Instruction memory with a built-in program loader, sitting directly upstream of the nRisc core. It receives a length-prefixed, checksummed byte stream over a valid/ready handshake and stores it in an internal 256x8 array. It holds the core in reset until a program has been loaded and verified. It then serves InstrucaoLida from the core's PC address every cycle, with no added latency.

Parameters:
PROFUNDIDADE, 256, number of 8-bit instruction words; address width is 8 bits.
INSTR_PADRAO, 8'h00, word returned for addresses outside the loaded program and in every non-run state.

Ports:
Clock  input  1  single system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
CargaValido  input  1  loader byte is valid this cycle.
CargaDado  input  8  loader byte.
CargaPronto  output  1  block accepts a loader byte this cycle.
Endereco  input  8  instruction address (core PCOut).
InstrucaoLida  output  8  instruction word to the core.
ResetProcessador  output  1  reset/hold for the core: 1 = core held, 0 = core runs.
Executando  output  1  block is in state EXECUTA.
ErroCarga  output  1  checksum mismatch detected; sticky until Reset.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high.
- Reset effects: state <- ESPERA_TAMANHO; counter, length and checksum accumulator <- 0; ErroCarga <- 0. Memory array contents are not cleared, but the stored length is 0, so nothing is readable.
- Values after the reset edge: CargaPronto=1, ResetProcessador=1, Executando=0, ErroCarga=0, InstrucaoLida=INSTR_PADRAO.
- Handshake: a byte transfers on a rising edge where CargaValido=1 and CargaPronto=1. CargaDado is ignored when either signal is low. CargaPronto is a pure function of state: 1 in ESPERA_TAMANHO, CARGA and VERIFICA; 0 in EXECUTA and ERRO.
- State ESPERA_TAMANHO:
  - The accepted byte is stored as length N in a 9-bit register; value 0 means N=256.
  - Clears the counter and checksum accumulator, then -> CARGA.
- State CARGA:
  - Each accepted byte is written to mem[counter] at that edge.
  - The accumulator adds the byte (8-bit sum, wraps mod 256) and the counter increments.
  - When the accepted byte is the N-th byte, -> VERIFICA.
- State VERIFICA:
  - The accepted byte is compared with the accumulator.
  - Equal -> EXECUTA at that edge.
  - Not equal -> ERRO and ErroCarga <- 1.
- State EXECUTA:
  - ResetProcessador=0 and Executando=1, so the core's first fetch is address 0 on the next edge after entry.
  - InstrucaoLida is a combinational read: mem[Endereco] if Endereco < N, else INSTR_PADRAO.
  - Loader bytes are ignored. The block leaves EXECUTA only through Reset.
- State ERRO: ResetProcessador=1, CargaPronto=0, InstrucaoLida=INSTR_PADRAO. The block leaves ERRO only through Reset.
- Output rules:
  - ResetProcessador=1 in every state except EXECUTA.
  - InstrucaoLida=INSTR_PADRAO in every state except EXECUTA.
  - ResetProcessador, Executando and ErroCarga are state-derived, with no combinational path from CargaValido.
- Simultaneous events: Reset has priority over a transfer in the same cycle; the byte is dropped and not written.
- Reset mid-load: the partial program is discarded and the block awaits a new length byte. Stale words beyond the new N are never readable.
- Wrap-around: the counter is 9 bits, so N=256 fills addresses 0..255 without an aliasing write.
- Endereco has no effect outside EXECUTA.

Test Plan:
- Basic load: stream 0x03, 0x41, 0x82, 0x07, 0xCA with valid held high -> after the 5th transfer Executando=1 and ResetProcessador=0. Endereco=1 gives 0x82, Endereco=2 gives 0x07, Endereco=3 gives 0x00.
- Bad checksum: stream 0x02, 0x10, 0x20, 0x31 -> ErroCarga=1, CargaPronto=0, ResetProcessador stays 1. Further bytes are ignored. After Reset, CargaPronto=1 and ErroCarga=0.
- Full depth: length 0x00, then bytes i=0..255, then checksum 0x80 -> EXECUTA is reached. Endereco=0xFF gives 0xFF and Endereco=0x00 gives 0x00.
- Backpressure and gaps: toggle CargaValido randomly while driving garbage on CargaDado during low-valid cycles, loading 0x01, 0x55, 0x55 -> only handshaken bytes are taken; Endereco=0 gives 0x55.
- Reset mid-load: after 0x05, 0xAA, 0xBB, assert Reset for 1 cycle, then load 0x01, 0x3C, 0x3C -> Endereco=0 gives 0x3C, Endereco=1 gives 0x00. InstrucaoLida=0x00 and ResetProcessador=1 throughout the load.
- Run-state Reset: in EXECUTA, hold CargaValido=1 (ignored), then assert Reset -> one edge later ResetProcessador=1, Executando=0, CargaPronto=1.
